// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the ram_arbiter block.
package ram_arb_pkg;

    // Controller states: INIT runs once after reset, RUN serves requests.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned D_WIDTH_DEF = 16;
    localparam int unsigned A_WIDTH_DEF = 5;
    localparam int unsigned N_REQ_DEF   = 4;

    // Width of the round-robin pointer for n requesters.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester channels plus RAM port wiring for ram_arbiter.
// master: the environment (requesters and the RAM); slave: the arbiter.
interface ram_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int unsigned D_WIDTH = D_WIDTH_DEF,
    parameter int unsigned A_WIDTH = A_WIDTH_DEF,
    parameter int unsigned N_REQ   = N_REQ_DEF
);
    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_write;
    logic [N_REQ*A_WIDTH-1:0] req_addr;
    logic [N_REQ*D_WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0]         rsp_valid;
    logic [D_WIDTH-1:0]       rsp_data;
    logic                     init_done;
    logic [A_WIDTH-1:0]       ram_address_write;
    logic [D_WIDTH-1:0]       ram_data_write;
    logic                     ram_write_enable;
    logic [A_WIDTH-1:0]       ram_address_read;
    logic [D_WIDTH-1:0]       ram_data_read;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, ram_data_read,
        input  req_ready, rsp_valid, rsp_data, init_done,
        input  ram_address_write, ram_data_write, ram_write_enable, ram_address_read
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, ram_data_read,
        output req_ready, rsp_valid, rsp_data, init_done,
        output ram_address_write, ram_data_write, ram_write_enable, ram_address_read
    );

endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr wins.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned N = N_REQ_DEF,
    localparam int unsigned PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_nxt_o,
    output logic          any_o
);

    localparam int unsigned SW = PW + 1;

    logic [SW-1:0] pos;
    logic [PW-1:0] idx;

    // Scan from ptr with wrap-around; pointer moves one past the winner.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        any_o     = 1'b0;
        pos       = '0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = SW'(ptr_i) + SW'(k);
            if (pos >= SW'(N)) begin
                pos = pos - SW'(N);
            end
            idx = PW'(pos);
            if (!any_o && req_i[idx]) begin
                any_o      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one simple dual-port RAM between N_REQ valid/ready requesters.
// Optional build macro RAM_ARB_INIT_EN: zero-fill the RAM in INIT before RUN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned D_WIDTH = D_WIDTH_DEF,
    parameter int unsigned A_WIDTH = A_WIDTH_DEF,
    parameter int unsigned N_REQ   = N_REQ_DEF
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam int unsigned PW = ptr_width(N_REQ);

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [N_REQ-1:0]   rd_pend_q, rd_pend_d;
    logic [A_WIDTH-1:0] waddr_q, waddr_d;
    logic [D_WIDTH-1:0] wdata_q, wdata_d;
    logic [A_WIDTH-1:0] raddr_q, raddr_d;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PW-1:0]      arb_ptr_nxt;
    logic               arb_any;

    logic               run_c;
    logic [N_REQ-1:0]   grant_c;
    logic               wr_go_c;
    logic               rd_go_c;
    logic [A_WIDTH-1:0] sel_addr_c;
    logic [D_WIDTH-1:0] sel_wdata_c;
    logic               init_wr_c;

`ifdef RAM_ARB_INIT_EN
    logic [A_WIDTH-1:0] cnt_q, cnt_d;
    logic               sweep_done_q, sweep_done_d;
`endif

    rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .req_i     (bus.req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .ptr_nxt_o (arb_ptr_nxt),
        .any_o     (arb_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: INIT leaves after one cycle, or after the sweep completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: begin
`ifdef RAM_ARB_INIT_EN
                if (sweep_done_q) begin
                    state_d = RUN;
                end
`else
                state_d = RUN;
`endif
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Outputs and datapath next values; everything is gated off during rst.
    always_comb begin
        run_c       = (state_q == RUN) && !rst;
        grant_c     = run_c ? arb_gnt : '0;
        wr_go_c     = 1'b0;
        rd_go_c     = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        init_wr_c   = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_c[i]) begin
                sel_addr_c  = bus.req_addr[i*A_WIDTH +: A_WIDTH];
                sel_wdata_c = bus.req_wdata[i*D_WIDTH +: D_WIDTH];
                wr_go_c     = bus.req_write[i];
                rd_go_c     = !bus.req_write[i];
            end
        end

        ptr_d     = (run_c && arb_any) ? arb_ptr_nxt : ptr_q;
        rd_pend_d = grant_c & ~bus.req_write;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        if (wr_go_c) begin
            waddr_d = sel_addr_c;
            wdata_d = sel_wdata_c;
        end
        if (rd_go_c) begin
            raddr_d = sel_addr_c;
        end

`ifdef RAM_ARB_INIT_EN
        cnt_d        = cnt_q;
        sweep_done_d = sweep_done_q;
        init_wr_c    = (state_q == INIT) && !rst && !sweep_done_q;
        if (init_wr_c) begin
            waddr_d = cnt_q;
            wdata_d = '0;
            cnt_d   = cnt_q + A_WIDTH'(1);
            if (cnt_q == '1) begin
                sweep_done_d = 1'b1;
            end
        end
`endif

        bus.req_ready         = grant_c;
        bus.ram_write_enable  = wr_go_c || init_wr_c;
        bus.ram_address_write = waddr_d;
        bus.ram_data_write    = wdata_d;
        bus.ram_address_read  = raddr_d;
        bus.rsp_valid         = rst ? '0 : rd_pend_q;
        bus.rsp_data          = bus.ram_data_read;
        bus.init_done         = run_c;
    end

    // Pointer, pending-read strobe and held RAM port values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            rd_pend_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_pend_q <= rd_pend_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
        end
    end

`ifdef RAM_ARB_INIT_EN
    // Sweep address counter and completion flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            sweep_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sweep_done_q <= sweep_done_d;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter with a behavioural model.
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int unsigned D     = 16;
    localparam int unsigned A     = 5;
    localparam int unsigned N     = 4;
    localparam int unsigned DEPTH = 32;
`ifdef RAM_ARB_INIT_EN
    localparam int INIT_CYC = 33;
`else
    localparam int INIT_CYC = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_arbiter_if #(.D_WIDTH(D), .A_WIDTH(A), .N_REQ(N)) bus ();

    ram_arbiter #(.D_WIDTH(D), .A_WIDTH(A), .N_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Simple dual-port RAM: write port plus registered read port.
    logic [D-1:0] ram_mem [DEPTH];
    logic [D-1:0] ram_rd;
    initial begin
        for (int a = 0; a < int'(DEPTH); a++) ram_mem[A'(a)] = 16'h5A00 | D'(a);
    end
    always @(posedge clk) begin
        ram_rd = ram_mem[bus.ram_address_read];
        if (bus.ram_write_enable) ram_mem[bus.ram_address_write] = bus.ram_data_write;
        bus.ram_data_read <= ram_rd;
    end

    int total = 0;
    int bad   = 0;

    // Stimulus fields
    logic         d_rst;
    logic [N-1:0] d_valid, d_write;
    logic [A-1:0] d_addr  [N];
    logic [D-1:0] d_wdata [N];

    // Reference model state
    logic [D-1:0] ref_mem [DEPTH];
    int           m_ptr, m_ptr_nxt, m_init_left;
    logic [N-1:0] exp_gnt, pend_nxt, exp_rsp_valid;
    logic [D-1:0] pend_data, exp_rsp_data, exp_wdata;
    logic [A-1:0] exp_waddr, exp_raddr;
    logic         exp_we, exp_rd, exp_init_done;

    // Apply stimulus for this cycle and predict the DUT's visible reaction.
    task automatic drive();
        logic [1:0] wi;
        bus.req_valid = d_valid;
        bus.req_write = d_write;
        bus.req_addr  = {d_addr[3], d_addr[2], d_addr[1], d_addr[0]};
        bus.req_wdata = {d_wdata[3], d_wdata[2], d_wdata[1], d_wdata[0]};
        rst = d_rst;
        #1;
        exp_gnt = '0; exp_we = 1'b0; exp_rd = 1'b0; pend_nxt = '0;
        m_ptr_nxt = m_ptr;
        exp_init_done = !d_rst && (m_init_left == 0);
        if (d_rst) exp_rsp_valid = '0;
        if (exp_init_done) begin
            for (int k = 0; k < int'(N); k++) begin
                wi = 2'((m_ptr + k) % int'(N));
                if (exp_gnt == '0 && d_valid[wi]) begin
                    exp_gnt[wi] = 1'b1;
                    m_ptr_nxt = (int'(wi) + 1) % int'(N);
                    if (d_write[wi]) begin
                        exp_we = 1'b1;
                        exp_waddr = d_addr[wi];
                        exp_wdata = d_wdata[wi];
                        ref_mem[d_addr[wi]] = d_wdata[wi];
                    end else begin
                        exp_rd = 1'b1;
                        exp_raddr = d_addr[wi];
                        pend_nxt[wi] = 1'b1;
                        pend_data = ref_mem[d_addr[wi]];
                    end
                end
            end
        end
    endtask

    // Advance one clock and move the model across the edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (d_rst) begin
            m_ptr = 0;
            exp_rsp_valid = '0;
            m_init_left = INIT_CYC;
`ifdef RAM_ARB_INIT_EN
            for (int a = 0; a < int'(DEPTH); a++) ref_mem[A'(a)] = '0;
`endif
        end else begin
            if (m_init_left > 0) m_init_left--;
            m_ptr = m_ptr_nxt;
            exp_rsp_valid = pend_nxt;
            exp_rsp_data = pend_data;
        end
    endtask

    task automatic idle_inputs();
        d_valid = '0;
        d_write = '0;
        for (int i = 0; i < int'(N); i++) begin
            d_addr[2'(i)]  = '0;
            d_wdata[2'(i)] = '0;
        end
    endtask

    // Reset and wait (by model count) until the block is running.
    task automatic do_reset();
        d_rst = 1'b1;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin drive(); tick(); end
        d_rst = 1'b0;
        for (int c = 0; c < 100 && m_init_left > 0; c++) begin drive(); tick(); end
    endtask

    task automatic test_reset();
        int n;
        d_rst = 1'b1;
        idle_inputs();
        d_valid = '1;
        for (int c = 0; c < 3; c++) begin
            drive();
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", bus.req_ready); end
            total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL reset_rsp got=%b want=0000", bus.rsp_valid); end
            total++; if (bus.ram_write_enable !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.ram_write_enable); end
            total++; if (bus.init_done !== 1'b0) begin bad++; $display("FAIL reset_init_done got=%b want=0", bus.init_done); end
            tick();
        end
        d_rst = 1'b0;
        n = 0;
        while (n < 100) begin
            drive();
            if (bus.init_done === 1'b1) break;
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL init_ready cyc=%0d got=%b want=0000", n, bus.req_ready); end
            tick();
            n++;
        end
        total++; if (n != INIT_CYC) begin bad++; $display("FAIL init_latency got=%0d want=%0d", n, INIT_CYC); end
        d_valid = '0;
        drive();
        tick();
    endtask

`ifdef RAM_ARB_INIT_EN
    task automatic test_sweep();
        idle_inputs();
        for (int a = 0; a <= int'(DEPTH); a++) begin
            d_valid = (a < int'(DEPTH)) ? 4'b0001 : 4'b0000;
            d_addr[0] = A'(a);
            drive();
            if (a > 0) begin
                total++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'h0000) begin
                    bad++; $display("FAIL sweep_zero addr=%0d got=%b/%h want=0001/0000", a - 1, bus.rsp_valid, bus.rsp_data);
                end
            end
            tick();
        end
    endtask
`endif

    task automatic test_write_read();
        do_reset();
        idle_inputs();
        d_valid = 4'b0100; d_write = 4'b0100; d_addr[2] = 5'd7; d_wdata[2] = 16'hBEEF;
        drive();
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL wr_ready got=%b want=0100", bus.req_ready); end
        total++; if ({bus.ram_write_enable, bus.ram_address_write, bus.ram_data_write} !== {1'b1, 5'd7, 16'hBEEF}) begin
            bad++; $display("FAIL wr_port got=%b/%0d/%h want=1/7/beef", bus.ram_write_enable, bus.ram_address_write, bus.ram_data_write);
        end
        tick();
        d_write = 4'b0000;
        drive();
        total++; if (bus.req_ready !== 4'b0100 || bus.ram_address_read !== 5'd7) begin
            bad++; $display("FAIL rd_accept got=%b/%0d want=0100/7", bus.req_ready, bus.ram_address_read);
        end
        total++; if (bus.ram_write_enable !== 1'b0) begin bad++; $display("FAIL rd_no_we got=%b want=0", bus.ram_write_enable); end
        tick();
        d_valid = '0;
        drive();
        total++; if (bus.rsp_valid !== 4'b0100 || bus.rsp_data !== 16'hBEEF) begin
            bad++; $display("FAIL rd_rsp got=%b/%h want=0100/beef", bus.rsp_valid, bus.rsp_data);
        end
        tick();
        drive();
        total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL rsp_one_cycle got=%b want=0000", bus.rsp_valid); end
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] want;
        do_reset();
        idle_inputs();
        for (int c = 0; c < 8; c++) begin
            d_valid = '1;
            for (int i = 0; i < int'(N); i++) d_addr[2'(i)] = A'($urandom_range(0, 31));
            drive();
            want = 4'b0001 << (c % 4);
            total++; if (bus.req_ready !== want) begin bad++; $display("FAIL fair_grant cyc=%0d got=%b want=%b", c, bus.req_ready, want); end
            total++; if (bus.rsp_valid !== exp_rsp_valid || (exp_rsp_valid != '0 && bus.rsp_data !== exp_rsp_data)) begin
                bad++; $display("FAIL fair_rsp cyc=%0d got=%b/%h want=%b/%h", c, bus.rsp_valid, bus.rsp_data, exp_rsp_valid, exp_rsp_data);
            end
            tick();
        end
    endtask

    task automatic test_single();
        d_valid = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            d_write[3] = 1'($urandom_range(0, 1));
            d_addr[3] = A'($urandom_range(0, 7));
            d_wdata[3] = D'($urandom);
            drive();
            total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL single_grant cyc=%0d got=%b want=1000", c, bus.req_ready); end
            tick();
        end
        d_valid = '1; d_write = '0;
        drive();
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ptr got=%b want=0001", bus.req_ready); end
        tick();
        d_valid = '0;
        drive();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] wi;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            drive();
            total++; if (bus.req_ready !== exp_gnt) begin bad++; $display("FAIL rnd_grant cyc=%0d got=%b want=%b", c, bus.req_ready, exp_gnt); end
            total++; if (bus.ram_write_enable !== exp_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b want=%b", c, bus.ram_write_enable, exp_we); end
            if (exp_we) begin
                total++; if (bus.ram_address_write !== exp_waddr || bus.ram_data_write !== exp_wdata) begin
                    bad++; $display("FAIL rnd_wport cyc=%0d got=%0d/%h want=%0d/%h", c, bus.ram_address_write, bus.ram_data_write, exp_waddr, exp_wdata);
                end
            end
            if (exp_rd) begin
                total++; if (bus.ram_address_read !== exp_raddr) begin bad++; $display("FAIL rnd_raddr cyc=%0d got=%0d want=%0d", c, bus.ram_address_read, exp_raddr); end
            end
            total++; if (bus.rsp_valid !== exp_rsp_valid) begin bad++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b want=%b", c, bus.rsp_valid, exp_rsp_valid); end
            if (exp_rsp_valid != '0) begin
                total++; if (bus.rsp_data !== exp_rsp_data) begin bad++; $display("FAIL rnd_rsp_data cyc=%0d got=%h want=%h", c, bus.rsp_data, exp_rsp_data); end
            end
            total++; if (bus.init_done !== exp_init_done) begin bad++; $display("FAIL rnd_init_done cyc=%0d got=%b want=%b", c, bus.init_done, exp_init_done); end
            // Held fields stay put until accepted; otherwise draw a new request.
            for (int i = 0; i < int'(N); i++) begin
                wi = 2'(i);
                if (!d_valid[wi] || exp_gnt[wi]) begin
                    d_valid[wi] = ($urandom_range(0, 3) != 0);
                    d_write[wi] = 1'($urandom_range(0, 1));
                    d_addr[wi]  = A'($urandom_range(0, 7));
                    d_wdata[wi] = D'($urandom);
                end
            end
            tick();
        end
        d_valid = '0;
        drive();
        tick();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        d_valid = 4'b0010; d_addr[1] = 5'd3;
        drive();
        total++; if (bus.req_ready !== exp_gnt) begin bad++; $display("FAIL mid_accept got=%b want=%b", bus.req_ready, exp_gnt); end
        tick();
        d_rst = 1'b1; d_valid = '0;
        for (int c = 0; c < 2; c++) begin
            drive();
            total++; if (bus.rsp_valid !== 4'b0000) begin bad++; $display("FAIL mid_rsp_drop cyc=%0d got=%b want=0000", c, bus.rsp_valid); end
            tick();
        end
        d_rst = 1'b0;
        for (int c = 0; c < 100 && m_init_left > 0; c++) begin
            drive();
            total++; if (bus.rsp_valid !== 4'b0000 || bus.req_ready !== 4'b0000) begin
                bad++; $display("FAIL mid_init cyc=%0d got=%b/%b want=0000/0000", c, bus.rsp_valid, bus.req_ready);
            end
            tick();
        end
        d_valid = '1;
        drive();
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr got=%b want=0001", bus.req_ready); end
        tick();
        d_valid = '0;
        drive();
        tick();
    endtask

    initial begin
        for (int a = 0; a < int'(DEPTH); a++) ref_mem[A'(a)] = 16'h5A00 | D'(a);
        m_ptr = 0; m_ptr_nxt = 0; m_init_left = INIT_CYC;
        exp_rsp_valid = '0; exp_rsp_data = '0; pend_nxt = '0; pend_data = '0;
        d_rst = 1'b1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
`ifdef RAM_ARB_INIT_EN
        test_sweep();
`endif
        test_write_read();
        test_fairness();
        test_single();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
